// File: rtl/secded_stream_decoder.sv
// SECDED (Hamming 15,11 + overall parity) decoder: walks NUM_MSG codewords in byte memory, writes flagged results.
// Latency: 6 cycles per codeword; done rises 6*NUM_MSG+1 cycles after the edge that samples init.
// Backpressure: none; the engine owns the memory port for a whole run. Optional stats via SECDED_STATS_EN.
module secded_stream_decoder #(
   parameter int NUM_MSG    = 15,
   parameter int SRC_BASE   = 30,
   parameter int DST_BASE   = 0,
   parameter int ADDR_W     = 8,
   parameter int CORRECT_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data,
   input  logic [7:0]        mem_rd_data
`ifdef SECDED_STATS_EN
   ,
   output logic [7:0]        sgl_cnt,
   output logic [7:0]        dbl_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAPT, DEC, WR_LO, WR_HI, DONE} state_t;

   localparam logic [6:0]        LAST_IDX = 7'(NUM_MSG - 1);
   localparam logic [ADDR_W-1:0] SRC      = ADDR_W'(SRC_BASE);
   localparam logic [ADDR_W-1:0] DST      = ADDR_W'(DST_BASE);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   state_t            state;
   logic [6:0]        idx;
   logic [7:0]        cw_lo;
   logic [7:0]        cw_hi;
   logic [7:0]        res_hi;

   logic              start;
   logic [15:0]       cw;
   logic [3:0]        syn;
   logic              is_sgl;
   logic              is_dbl;
   logic [10:0]       d_rx;
   logic [10:0]       flip;
   logic [10:0]       d_fix;
   logic [15:0]       dec_res;
   logic [6:0]        idx_nxt;
   logic [ADDR_W-1:0] src_lo;
   logic [ADDR_W-1:0] src_nxt;
   logic [ADDR_W-1:0] dst_lo;

   // init is only honoured while parked; mid-run pulses fall through
   assign start   = init && (state == IDLE || state == DONE);
   assign cw      = {cw_hi, cw_lo};
   assign idx_nxt = idx + 7'd1;
   // Address arithmetic deliberately wraps modulo 2^ADDR_W
   assign src_lo  = SRC + ADDR_W'({idx, 1'b0});
   assign src_nxt = SRC + ADDR_W'({idx_nxt, 1'b0});
   assign dst_lo  = DST + ADDR_W'({idx, 1'b0});

   // Syndrome/parity decode of the captured codeword and result formatting
   always_comb begin
      syn = 4'd0;
      for (int i = 1; i < 16; i++) begin
         if (cw[i]) syn = syn ^ 4'(i);
      end
      is_sgl = ^cw;
      is_dbl = !is_sgl && (syn != 4'd0);
      d_rx   = {cw[15:9], cw[7:5], cw[3]};
      // Only a syndrome pointing at a data position changes the payload
      flip   = {syn == 4'd15, syn == 4'd14, syn == 4'd13, syn == 4'd12,
                syn == 4'd11, syn == 4'd10, syn == 4'd9,  syn == 4'd7,
                syn == 4'd6,  syn == 4'd5,  syn == 4'd3};
      if (!is_sgl || CORRECT_EN == 0) flip = '0;
      d_fix  = d_rx ^ flip;
      if (is_dbl)      dec_res = {5'b10000, d_rx};
      else if (is_sgl) dec_res = {5'b01000, d_fix};
      else             dec_res = {5'b00000, d_rx};
   end

   // Run sequencer; memory-port outputs are registered for the state being entered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         idx         <= '0;
         cw_lo       <= '0;
         cw_hi       <= '0;
         res_hi      <= '0;
         done        <= 1'b0;
         mem_addr    <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RD_LO;
                  idx      <= '0;
                  mem_addr <= SRC;
               end
            end
            RD_LO: begin
               state    <= RD_HI;
               mem_addr <= src_lo + ONE;
            end
            RD_HI: begin
               cw_lo    <= mem_rd_data;
               state    <= CAPT;
               mem_addr <= '0;
            end
            CAPT: begin
               cw_hi <= mem_rd_data;
               state <= DEC;
            end
            DEC: begin
               res_hi      <= dec_res[15:8];
               mem_wr_data <= dec_res[7:0];
               mem_wr_en   <= 1'b1;
               mem_addr    <= dst_lo;
               state       <= WR_LO;
            end
            WR_LO: begin
               mem_addr    <= dst_lo + ONE;
               mem_wr_data <= res_hi;
               state       <= WR_HI;
            end
            WR_HI: begin
               mem_wr_en   <= 1'b0;
               mem_wr_data <= '0;
               if (idx < LAST_IDX) begin
                  idx      <= idx_nxt;
                  mem_addr <= src_nxt;
                  state    <= RD_LO;
               end else begin
                  mem_addr <= '0;
                  state    <= DONE;
               end
            end
            DONE: begin
               // done is a level; a new init drops it and restarts from message 0
               if (start) begin
                  done     <= 1'b0;
                  idx      <= '0;
                  mem_addr <= SRC;
                  state    <= RD_LO;
               end else begin
                  done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SECDED_STATS_EN
   // Per-run error-class counters: cleared on start, bumped once per codeword in DEC, saturating
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sgl_cnt <= '0;
         dbl_cnt <= '0;
      end else if (start) begin
         sgl_cnt <= '0;
         dbl_cnt <= '0;
      end else if (state == DEC) begin
         if (is_sgl && sgl_cnt != 8'hFF) sgl_cnt <= sgl_cnt + 8'd1;
         if (is_dbl && dbl_cnt != 8'hFF) dbl_cnt <= dbl_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Bench for secded_stream_decoder: table-driven codewords, write-port scoreboard, abort and detect-only runs.
// Two instances: defaults, and a detect-only in-place copy whose buffer wraps past address 255.
// All memory modelling and checking run from one process, sampled on the falling edge.
`timescale 1ns/1ps
module tb_secded_stream_decoder;
   localparam int N1    = 15;
   localparam int SRC1  = 30;
   localparam int DST1  = 0;
   localparam int N2    = 4;
   localparam int BASE2 = 252;
   localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

   typedef struct { logic [15:0] cw; logic [15:0] res; } vec_t;
   typedef struct { logic [7:0] addr; logic [15:0] res; } exp_t;

   logic       clk;
   logic       reset;
   logic       init1, init2;
   logic       done1, wr1, done2, wr2;
   logic [7:0] addr1, wd1, rd1, addr2, wd2, rd2;
`ifdef SECDED_STATS_EN
   logic [7:0] sgl1, dbl1, sgl2, dbl2;
`endif
   logic [7:0] mem1 [256];
   logic [7:0] mem2 [256];
   exp_t       q1[$];
   exp_t       q2[$];
   vec_t       tab_a [N1];
   vec_t       tab_b [N1];
   vec_t       tab_c [N2];
   int         vectors, miscompares;
   logic       pend1, pend2;
   logic [7:0] lo1, loa1, lo2, loa2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   secded_stream_decoder u_dut (
      .clk(clk), .reset(reset), .init(init1), .done(done1),
      .mem_addr(addr1), .mem_wr_en(wr1), .mem_wr_data(wd1), .mem_rd_data(rd1)
`ifdef SECDED_STATS_EN
      , .sgl_cnt(sgl1), .dbl_cnt(dbl1)
`endif
   );

   secded_stream_decoder #(
      .NUM_MSG(N2), .SRC_BASE(BASE2), .DST_BASE(BASE2), .ADDR_W(8), .CORRECT_EN(0)
   ) u_dut_nc (
      .clk(clk), .reset(reset), .init(init2), .done(done2),
      .mem_addr(addr2), .mem_wr_en(wr2), .mem_wr_data(wd2), .mem_rd_data(rd2)
`ifdef SECDED_STATS_EN
      , .sgl_cnt(sgl2), .dbl_cnt(dbl2)
`endif
   );

   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] cw;
      logic        p;
      cw = '0;
      for (int k = 0; k < 11; k++) cw[DPOS[k]] = d[k];
      for (int b = 0; b < 4; b++) begin
         p = 1'b0;
         for (int i = 1; i < 16; i++)
            if (((i >> b) & 1) == 1 && i != (1 << b)) p = p ^ cw[i];
         cw[1 << b] = p;
      end
      cw[0] = ^cw[15:1];
      return cw;
   endfunction

   function automatic logic [10:0] d_of(input logic [15:0] x);
      logic [10:0] d;
      for (int k = 0; k < 11; k++) d[k] = x[DPOS[k]];
      return d;
   endfunction

   function automatic logic [15:0] model(input logic [15:0] cw, input logic corr);
      logic [3:0]  s;
      logic [15:0] fixed;
      s = 4'd0;
      for (int b = 0; b < 4; b++)
         for (int i = 1; i < 16; i++)
            if (((i >> b) & 1) == 1) s[b] = s[b] ^ cw[i];
      if (^cw) begin
         fixed = cw;
         if (corr) fixed[s] = ~fixed[s];
         return {5'b01000, d_of(fixed)};
      end
      if (s != 4'd0) return {5'b10000, d_of(cw)};
      return {5'b00000, d_of(cw)};
   endfunction

   // kind: 0 single flip, 1 double flip, 2 same bit flipped twice, 3 clean
   function automatic vec_t rand_vec(input int kind);
      logic [15:0] cw;
      int          a, b;
      cw = encode(11'($urandom));
      a  = $urandom_range(0, 15);
      b  = (a + $urandom_range(1, 15)) % 16;
      case (kind % 4)
         0: cw[a] = ~cw[a];
         1: begin cw[a] = ~cw[a]; cw[b] = ~cw[b]; end
         2: begin cw[a] = ~cw[a]; cw[a] = ~cw[a]; end
         default: ;
      endcase
      return '{cw: cw, res: model(cw, 1'b1)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic mon(input string nm, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                      inout logic pend, inout logic [7:0] lo, inout logic [7:0] loa, input int which);
      exp_t e;
      logic have;
      if (!reset) pend = 1'b0;
      else if (wr) begin
         if (!pend) begin
            pend = 1'b1; lo = wd; loa = a;
         end else begin
            pend = 1'b0;
            have = 1'b0;
            e    = '{addr: '0, res: '0};
            if (which == 1) begin
               if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
            end else begin
               if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
            end
            vectors++;
            if (!have) begin
               miscompares++;
               $display("FAIL %s: unexpected result %h at %0d, required no write", nm, {wd, lo}, loa);
            end else if ({wd, lo} !== e.res || loa !== e.addr || a !== 8'(e.addr + 8'd1)) begin
               miscompares++;
               $display("FAIL %s: result %h at %0d/%0d, required %h at %0d", nm, {wd, lo}, loa, a, e.res, e.addr);
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      rd1 <= mem1[addr1];
      if (wr1) mem1[addr1] <= wd1;
      rd2 <= mem2[addr2];
      if (wr2) mem2[addr2] <= wd2;
      @(negedge clk);
      mon("dut write", wr1, addr1, wd1, pend1, lo1, loa1, 1);
      mon("dut_nc write", wr2, addr2, wd2, pend2, lo2, loa2, 2);
   endtask

   task automatic load1(input int which_tab);
      vec_t v;
      for (int i = 0; i < N1; i++) begin
         if (which_tab == 0) v = tab_a[i];
         else                v = tab_b[i];
         mem1[8'(SRC1 + 2 * i)]     <= v.cw[7:0];
         mem1[8'(SRC1 + 2 * i + 1)] <= v.cw[15:8];
         q1.push_back('{addr: 8'(DST1 + 2 * i), res: v.res});
      end
   endtask

   // Pulse init, then count edges until done; pulse_at >= 0 injects a stray init mid-run
   task automatic run(input string nm, input int which, input int req_cycles, input int pulse_at);
      int cnt;
      cnt = 0;
      if (which == 1) init1 = 1'b1; else init2 = 1'b1;
      step();
      init1 = 1'b0; init2 = 1'b0;
      chk({nm, " done low after start"}, (which == 1) ? done1 : done2, 0);
      while (cnt < 300) begin
         if (cnt == pulse_at) begin
            if (which == 1) init1 = 1'b1; else init2 = 1'b1;
         end else begin
            init1 = 1'b0; init2 = 1'b0;
         end
         step();
         cnt++;
         if (((which == 1) ? done1 : done2) === 1'b1) break;
      end
      init1 = 1'b0; init2 = 1'b0;
      chk({nm, " done latency"}, cnt, req_cycles);
   endtask

   initial begin
      int   es, ed;
      logic found;
      logic [15:0] r;
      vectors = 0; miscompares = 0;
      pend1 = 1'b0; pend2 = 1'b0; lo1 = '0; loa1 = '0; lo2 = '0; loa2 = '0;
      reset = 1'b0; init1 = 1'b0; init2 = 1'b0;
      rd1 <= 8'h00; rd2 <= 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem1[i] <= 8'hA5;
         mem2[i] <= 8'hA5;
      end

      tab_a[0] = '{cw: 16'hFFFF, res: 16'h07FF};
      tab_a[1] = '{cw: 16'hFFFE, res: 16'h47FF};
      tab_a[2] = '{cw: 16'h0020, res: 16'h4000};
      tab_a[3] = '{cw: 16'h0220, res: 16'h8012};
      tab_a[4] = '{cw: 16'h000F, res: 16'h0001};
      tab_a[5] = '{cw: 16'h0007, res: 16'h4001};
      tab_a[6] = '{cw: 16'h000C, res: 16'h8001};
      tab_a[7] = '{cw: 16'h0000, res: 16'h0000};
      tab_a[8] = '{cw: 16'h8000, res: 16'h4000};
      for (int i = 9; i < N1; i++) tab_a[i] = rand_vec(i);
      for (int i = 0; i < N1; i++) tab_b[i] = rand_vec(i + 1);
      tab_c[0] = '{cw: 16'h0020, res: 16'h4002};
      tab_c[1] = '{cw: 16'h0007, res: 16'h4000};
      tab_c[2] = '{cw: 16'h8000, res: 16'h4400};
      tab_c[3] = '{cw: 16'hFFFF, res: 16'h07FF};

      // Reset values
      step(); step();
      chk("reset done", done1, 0);
      chk("reset mem_wr_en", wr1, 0);
      chk("reset mem_addr", addr1, 0);
      chk("reset mem_wr_data", wd1, 0);
      chk("reset done nc", done2, 0);
`ifdef SECDED_STATS_EN
      chk("reset sgl_cnt", sgl1, 0);
      chk("reset dbl_cnt", dbl1, 0);
`endif
      reset = 1'b1;
      step();

      // Run A: directed + random table, stray init pulse mid-run
      load1(0);
      run("run A", 1, 6 * N1 + 1, 40);
      chk("run A queue drained", q1.size(), 0);
`ifdef SECDED_STATS_EN
      es = 0; ed = 0;
      for (int i = 0; i < N1; i++) begin es += int'(tab_a[i].res[14]); ed += int'(tab_a[i].res[15]); end
      chk("run A sgl_cnt", sgl1, es);
      chk("run A dbl_cnt", dbl1, ed);
`endif
      step(); step(); step();
      chk("done holds", done1, 1);

      // Run B from DONE, aborted by reset during WR_LO of message 3
      load1(1);
      init1 = 1'b1;
      step();
      init1 = 1'b0;
      chk("done cleared by restart", done1, 0);
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         step();
         if (wr1 && addr1 == 8'(DST1 + 6)) found = 1'b1;
      end
      chk("reached WR_LO of msg 3", found, 1);
      #1 reset = 1'b0;
      #1;
      chk("abort done", done1, 0);
      chk("abort mem_wr_en", wr1, 0);
      chk("abort mem_addr", addr1, 0);
      chk("abort mem_wr_data", wd1, 0);
      q1.delete();
      pend1 = 1'b0;
      step();
      for (int i = 0; i < 6; i++) begin
         r = tab_b[i / 2].res;
         chk("abort keeps msgs 0-2", mem1[8'(DST1 + i)], (i % 2 == 1) ? r[15:8] : r[7:0]);
      end
      chk("abort no partial lo write", mem1[8'(DST1 + 6)], tab_a[3].res[7:0]);
      chk("abort no partial hi write", mem1[8'(DST1 + 7)], tab_a[3].res[15:8]);
`ifdef SECDED_STATS_EN
      chk("abort sgl_cnt", sgl1, 0);
`endif

      // Rerun B in full after the abort
      reset = 1'b1;
      step();
      load1(1);
      run("rerun B", 1, 6 * N1 + 1, -1);
      chk("rerun B queue drained", q1.size(), 0);

      // Detect-only instance, in place, buffer wraps past 255
      for (int i = 0; i < N2; i++) begin
         mem2[8'(BASE2 + 2 * i)]     <= tab_c[i].cw[7:0];
         mem2[8'(BASE2 + 2 * i + 1)] <= tab_c[i].cw[15:8];
         q2.push_back('{addr: 8'(BASE2 + 2 * i), res: tab_c[i].res});
      end
      run("detect-only", 2, 6 * N2 + 1, -1);
      chk("detect-only queue drained", q2.size(), 0);
      for (int i = 0; i < 2 * N2; i++) begin
         r = tab_c[i / 2].res;
         chk("detect-only in-place memory", mem2[8'(BASE2 + i)], (i % 2 == 1) ? r[15:8] : r[7:0]);
      end
`ifdef SECDED_STATS_EN
      chk("detect-only sgl_cnt", sgl2, 3);
      chk("detect-only dbl_cnt", dbl2, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/secded_stream_decoder.md
# secded_stream_decoder

Hardware SECDED (Hamming 15,11 + overall parity) decoder engine that replaces the program-2 software loop. On an `init` request it walks `NUM_MSG` 16-bit codewords stored little-endian in byte-wide data memory starting at `SRC_BASE`. It corrects single-bit errors, flags double-bit errors, and writes flagged 16-bit results to `DST_BASE`, then raises `done`. It sits beside the core as a second master on the data-memory port and uses the same init/done handshake as `top_level`.

## Interface
- `NUM_MSG`, default 15: codewords processed per run (1..127).
- `SRC_BASE`, default 30: byte address of codeword 0 low byte.
- `DST_BASE`, default 0: byte address of result 0 low byte.
- `ADDR_W`, default 8: memory address width.
- `CORRECT_EN`, default 1: 1 = correct single errors; 0 = detect-only, data passed uncorrected, flags still set.
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `init`, in, 1: start request, sampled in IDLE.
- `done`, out, 1: run complete, level.
- `mem_addr`, out, ADDR_W: byte address.
- `mem_wr_en`, out, 1: write strobe.
- `mem_wr_data`, out, 8: write byte.
- `mem_rd_data`, in, 8: read byte, valid one cycle after `mem_addr`.
- `sgl_cnt`, `dbl_cnt`, out, 8: error counters; present only with `SECDED_STATS_EN`.

## Operation
- Codeword bit map [15:0]: d11..d5, p8, d4..d2, p4, d1, p2, p1, p0.
- Message i: low byte at `SRC_BASE+2i`, high byte at `SRC_BASE+2i+1`. Result low at `DST_BASE+2i`, high at `DST_BASE+2i+1`.
- Syndrome s[3:0] = XOR of the indices of set bits at positions 1..15. P = XOR of all 16 bits.
- s=0, P=0: no error. Result = {5'b00000, d[11:1]}.
- P=1: single error at position s (s=0 means p0). Flip the bit if `CORRECT_EN`. Result = {5'b01000, d}.
- s≠0, P=0: double error. Result = {5'b10000, received d}.
- States: IDLE, RD_LO, RD_HI, CAPT, DEC, WR_LO, WR_HI, DONE.
- IDLE→RD_LO when `init`=1. The message index clears, and so do the counters under the macro.
- RD_LO drives the source low address. RD_HI drives the source high address and captures the low byte. CAPT captures the high byte. DEC registers the result and flags. WR_LO and WR_HI write one byte each.
- After WR_HI, the FSM goes to RD_LO with index+1 if index<NUM_MSG-1, else to DONE.
- DONE holds `done`=1 until `init` rises again. That edge clears `done` and restarts the run, returning to RD_LO.
- `init` is ignored in every state other than IDLE and DONE.
- `mem_wr_en` is high only in WR_LO and WR_HI.
- `mem_addr` is a don't-care in IDLE, CAPT, DEC and DONE, and is driven as 0 there.

## Timing
- Exactly 6 cycles per message. `done` rises 6·NUM_MSG+1 cycles after the edge that samples `init`; 91 cycles for the defaults.
- Source and destination ranges may overlap. Each message's reads complete before its writes, so in-place operation (SRC_BASE=DST_BASE) is legal.
- Reset values: `done`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, counters=0, state=IDLE, index=0.
- Reset mid-run aborts immediately. Bytes already written are not restored, and no partial write completes.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is permitted and not flagged.

## Configuration
- `SECDED_STATS_EN` defined: `sgl_cnt` and `dbl_cnt` exist. Each increments in DEC for its error class, saturates at 255, and clears on `init` acceptance.
- `SECDED_STATS_EN` undefined: ports and logic are absent, and run behaviour and timing are identical.

## Test plan
- Codeword 0xFFFF (d=0x7FF) → result 0x07FF. `done` rises after 91 cycles with the defaults.
- 0xFFFE (p0 flipped) → 0x47FF. 0x0020 (d2 flipped, d=0) → 0x4000.
- 0x0220 (two flips, d=0) → bit15=1 and bit14=0. With the macro, `dbl_cnt`=1.
- `CORRECT_EN`=0 with input 0x0020 → 0x4002. The flag is set and the data is uncorrected.
- Assert `reset` low during WR_LO of message 3. Required: all outputs go to 0 immediately; results for messages 0–2 stay intact; a following `init` reruns all 15 messages correctly.
- Random 15-message run mixing single, double and cancelling flips (same bit flipped twice) → 15/15 results match the behavioural model. Pulsing `init` mid-run has no effect.
